// File: rtl/clock_pkg.sv
// Shared types and digit limits for the alarm clock time path.
// Every BCD field is one 4-bit digit.
package clock_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t MIN_LS_MAX      = 4'd9;
    localparam digit_t MIN_MS_MAX      = 4'd5;
    localparam digit_t HR_LS_MAX       = 4'd9;
    localparam digit_t HR_MS_MAX       = 4'd2;
    localparam digit_t HR_LS_MAX_AT_20 = 4'd3;

    function automatic logic time_valid(
        input digit_t hr_ms,
        input digit_t hr_ls,
        input digit_t min_ms,
        input digit_t min_ls
    );
        logic hr_ok;
        hr_ok = (hr_ms < HR_MS_MAX && hr_ls <= HR_LS_MAX) ||
                (hr_ms == HR_MS_MAX && hr_ls <= HR_LS_MAX_AT_20);
        return hr_ok && min_ms <= MIN_MS_MAX && min_ls <= MIN_LS_MAX;
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// Strobe and BCD bus between the timing generator/alarm controller
// and the time counter; slave is the counter side.
interface time_counter_if;
    import clock_pkg::*;

    logic   one_minute;
    logic   one_second;
    logic   load_time;
    digit_t new_hr_ms;
    digit_t new_hr_ls;
    digit_t new_min_ms;
    digit_t new_min_ls;
    digit_t cur_hr_ms;
    digit_t cur_hr_ls;
    digit_t cur_min_ms;
    digit_t cur_min_ls;
    logic   day_wrap;
    logic   load_error;
    logic   colon;

    modport master (
        output one_minute, one_second, load_time,
        output new_hr_ms, new_hr_ls, new_min_ms, new_min_ls,
        input  cur_hr_ms, cur_hr_ls, cur_min_ms, cur_min_ls,
        input  day_wrap, load_error, colon
    );

    modport slave (
        input  one_minute, one_second, load_time,
        input  new_hr_ms, new_hr_ls, new_min_ms, new_min_ls,
        output cur_hr_ms, cur_hr_ls, cur_min_ms, cur_min_ls,
        output day_wrap, load_error, colon
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..wrap_val; load has priority over inc.
// carry_out is combinational so the next digit steps in the same edge.
module bcd_digit
    import clock_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   inc,
    input  logic   load,
    input  digit_t load_val,
    input  digit_t wrap_val,
    output digit_t value,
    output logic   carry_out
);

    assign carry_out = inc && (value == wrap_val);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= (value == wrap_val) ? 4'd0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/time_counter.sv
// HH:MM time-of-day counter: minute advance, validated load,
// day wrap pulse and a second-rate display colon.
module time_counter
    import clock_pkg::*;
(
    input logic           clock,
    input logic           reset,
    time_counter_if.slave tc
);

    digit_t min_ls, min_ms, hr_ls, hr_ms;
    logic   min_ls_co, min_ms_co, hr_ls_co, hr_ms_co;
    logic   load_ok, advance, at_23, day_end;
    logic   hr_load;
    digit_t hr_ms_val, hr_ls_val;

    assign load_ok = tc.load_time &&
                     time_valid(tc.new_hr_ms, tc.new_hr_ls,
                                tc.new_min_ms, tc.new_min_ls);
    // A load of either kind swallows a coincident minute.
    assign advance = tc.one_minute && !tc.load_time;
    assign at_23   = (hr_ms == HR_MS_MAX) && (hr_ls == HR_LS_MAX_AT_20);
    assign day_end = min_ms_co && at_23;

    // 23 -> 00 is done by loading zero into both hour digits.
    assign hr_load   = load_ok || day_end;
    assign hr_ms_val = load_ok ? tc.new_hr_ms : 4'd0;
    assign hr_ls_val = load_ok ? tc.new_hr_ls : 4'd0;

    bcd_digit u_min_ls (
        .clock     (clock),
        .reset     (reset),
        .inc       (advance),
        .load      (load_ok),
        .load_val  (tc.new_min_ls),
        .wrap_val  (MIN_LS_MAX),
        .value     (min_ls),
        .carry_out (min_ls_co)
    );

    bcd_digit u_min_ms (
        .clock     (clock),
        .reset     (reset),
        .inc       (min_ls_co),
        .load      (load_ok),
        .load_val  (tc.new_min_ms),
        .wrap_val  (MIN_MS_MAX),
        .value     (min_ms),
        .carry_out (min_ms_co)
    );

    bcd_digit u_hr_ls (
        .clock     (clock),
        .reset     (reset),
        .inc       (min_ms_co && !at_23),
        .load      (hr_load),
        .load_val  (hr_ls_val),
        .wrap_val  (HR_LS_MAX),
        .value     (hr_ls),
        .carry_out (hr_ls_co)
    );

    bcd_digit u_hr_ms (
        .clock     (clock),
        .reset     (reset),
        .inc       (hr_ls_co),
        .load      (hr_load),
        .load_val  (hr_ms_val),
        .wrap_val  (HR_MS_MAX),
        .value     (hr_ms),
        .carry_out (hr_ms_co)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tc.day_wrap   <= 1'b0;
            tc.load_error <= 1'b0;
            tc.colon      <= 1'b1;
        end else begin
            tc.day_wrap   <= advance && day_end;
            tc.load_error <= tc.load_time && !load_ok;
            if (load_ok)
                tc.colon <= 1'b1;
            else if (tc.one_second)
                tc.colon <= ~tc.colon;
        end
    end

    assign tc.cur_hr_ms  = hr_ms;
    assign tc.cur_hr_ls  = hr_ls;
    assign tc.cur_min_ms = min_ms;
    assign tc.cur_min_ls = min_ls;

    logic unused_carry;
    assign unused_carry = hr_ms_co;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: minutes-of-day model checked every cycle
// plus directed scenarios with literal expectations.
module tb_time_counter;

    logic clock;
    logic reset;

    time_counter_if tif ();

    time_counter dut (
        .clock (clock),
        .reset (reset),
        .tc    (tif.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_pass  = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: time kept as minutes since midnight.
    int   m_min;
    logic m_colon, m_dw, m_le;

    function automatic int bcd_of(input int m);
        int h, mm;
        h  = m / 60;
        mm = m % 60;
        return ((h / 10) << 12) | ((h % 10) << 8) | ((mm / 10) << 4) | (mm % 10);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_min   = 0;
            m_colon = 1'b1;
            m_dw    = 1'b0;
            m_le    = 1'b0;
        end else begin
            int hm, hl, mm, ml;
            bit ok;
            hm = int'(tif.new_hr_ms);
            hl = int'(tif.new_hr_ls);
            mm = int'(tif.new_min_ms);
            ml = int'(tif.new_min_ls);
            ok = hl <= 9 && ml <= 9 && mm <= 5 && (hm * 10 + hl) <= 23;
            m_dw = 1'b0;
            m_le = 1'b0;
            if (tif.load_time && ok) begin
                m_min   = (hm * 10 + hl) * 60 + mm * 10 + ml;
                m_colon = 1'b1;
            end else begin
                if (tif.load_time)
                    m_le = 1'b1;
                else if (tif.one_minute) begin
                    m_min = (m_min + 1) % 1440;
                    m_dw  = (m_min == 0);
                end
                if (tif.one_second)
                    m_colon = ~m_colon;
            end
        end
    end

    function automatic int cur_bcd();
        return {16'd0, tif.cur_hr_ms, tif.cur_hr_ls, tif.cur_min_ms, tif.cur_min_ls};
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_cur", cur_bcd(), bcd_of(m_min));
            check("model_colon", int'(tif.colon), int'(m_colon));
            check("model_day_wrap", int'(tif.day_wrap), int'(m_dw));
            check("model_load_error", int'(tif.load_error), int'(m_le));
        end
    end

    task automatic step(input logic om, input logic os, input logic lt,
                        input logic [15:0] d);
        @(negedge clock);
        tif.one_minute = om;
        tif.one_second = os;
        tif.load_time  = lt;
        tif.new_hr_ms  = d[15:12];
        tif.new_hr_ls  = d[11:8];
        tif.new_min_ms = d[7:4];
        tif.new_min_ls = d[3:0];
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        logic [15:0] bad [3];
        bad[0] = 16'h2400;
        bad[1] = 16'h1260;
        bad[2] = 16'h1A00;

        tif.one_minute = 1'b0;
        tif.one_second = 1'b0;
        tif.load_time  = 1'b0;
        tif.new_hr_ms  = '0;
        tif.new_hr_ls  = '0;
        tif.new_min_ms = '0;
        tif.new_min_ls = '0;
        reset = 1'b1;
        #12;
        check("reset_cur", cur_bcd(), 16'h0000);
        check("reset_colon", int'(tif.colon), 1);
        check("reset_day_wrap", int'(tif.day_wrap), 0);
        check("reset_load_error", int'(tif.load_error), 0);
        @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
        idle();
        check("eight_min_cur", cur_bcd(), 16'h0008);
        check("eight_min_colon", int'(tif.colon), 1);

        step(1'b0, 1'b0, 1'b1, 16'h2358);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("load_2358", cur_bcd(), 16'h2358);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("to_2359", cur_bcd(), 16'h2359);
        check("no_wrap_2359", int'(tif.day_wrap), 0);
        idle();
        check("wrap_cur", cur_bcd(), 16'h0000);
        check("wrap_pulse", int'(tif.day_wrap), 1);
        idle();
        check("wrap_one_cycle", int'(tif.day_wrap), 0);

        step(1'b0, 1'b0, 1'b1, 16'h0959);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        idle();
        check("0959_to_1000", cur_bcd(), 16'h1000);
        step(1'b0, 1'b0, 1'b1, 16'h1959);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        idle();
        check("1959_to_2000", cur_bcd(), 16'h2000);
        step(1'b0, 1'b0, 1'b1, 16'h1234);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        idle();
        check("1234_to_1235", cur_bcd(), 16'h1235);

        step(1'b0, 1'b0, 1'b1, 16'h0715);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, bad[i]);
            idle();
            check("bad_load_error", int'(tif.load_error), 1);
            check("bad_load_hold", cur_bcd(), 16'h0715);
        end

        step(1'b0, 1'b1, 1'b0, 16'h0000);
        idle();
        check("colon_toggled", int'(tif.colon), 0);
        step(1'b1, 1'b1, 1'b1, 16'h1200);
        idle();
        check("load_beats_min", cur_bcd(), 16'h1200);
        check("load_colon", int'(tif.colon), 1);

        step(1'b0, 1'b0, 1'b1, 16'h0100);
        step(1'b0, 1'b0, 1'b1, 16'h0200);
        idle();
        check("b2b_load_last", cur_bcd(), 16'h0200);

        step(1'b0, 1'b0, 1'b1, 16'h1542);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("pre_reset_cur", cur_bcd(), 16'h1542);
        check("pre_reset_colon", int'(tif.colon), 0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_cur", cur_bcd(), 16'h0000);
        check("async_reset_colon", int'(tif.colon), 1);
        @(negedge clock);
        reset = 1'b0;
        idle();
        check("resume_cur", cur_bcd(), 16'h0001);

        idle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
